// File: rtl/dcim_pkg.sv
// Shared DCIM definitions: shift-accumulator state encoding, default sizes and
// the plane-counter width helper.
package dcim_pkg;

  localparam int DCIM_PSUM_W   = 16;
  localparam int DCIM_ACT_BITS = 8;
  localparam int DCIM_ACC_W    = 24;

  typedef enum logic [1:0] {
    SACC_IDLE  = 2'd0,
    SACC_ACCUM = 2'd1,
    SACC_DONE  = 2'd2
  } sacc_state_e;

  // Plane counter width; ACT_BITS is at least 2, so this is at least 1.
  function automatic int sacc_cnt_w(input int act_bits);
    return (act_bits < 2) ? 1 : $clog2(act_bits);
  endfunction

endpackage

// File: rtl/dcim_shift_acc_if.sv
// Bus between the column adder tree / readout stage and the shift-accumulator.
interface dcim_shift_acc_if #(
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 24
) ();

  // Handshakes: a psum beat transfers on a rising clk edge where in_valid and
  // in_ready are both 1; a result transfers where out_valid and out_ready are
  // both 1. The master may not withdraw or change psum/out-side data while its
  // valid is high and the transfer has not happened. ready never waits on valid.
  logic              start;
  logic              act_signed;
  logic              in_valid;
  logic              in_ready;
  logic [PSUM_W-1:0] psum;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;
  logic              relu_clip;

  modport master (
    output start, act_signed, in_valid, psum, out_ready,
    input  in_ready, out_valid, out_data, busy, relu_clip
  );

  modport slave (
    input  start, act_signed, in_valid, psum, out_ready,
    output in_ready, out_valid, out_data, busy, relu_clip
  );

endinterface

// File: rtl/dcim_shift_acc.sv
// Bit-serial shift-accumulator for one DCIM column: folds MSB-first bit-plane
// partial sums into a dot product. Optional clamp: define DCIM_SACC_RELU_EN.
module dcim_shift_acc
  import dcim_pkg::*;
#(
  parameter int PSUM_W   = DCIM_PSUM_W,
  parameter int ACT_BITS = DCIM_ACT_BITS,
  parameter int ACC_W    = DCIM_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  dcim_shift_acc_if.slave    bus,
  output sacc_state_e        state_dbg_o
);

  localparam int CNT_W = sacc_cnt_w(ACT_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACT_BITS - 1);

  if (ACT_BITS < 2 || ACT_BITS > 16) begin : g_bad_act_bits
    $error("dcim_shift_acc: ACT_BITS must be in 2..16");
  end
  if (ACC_W < PSUM_W + ACT_BITS) begin : g_bad_acc_w
    $error("dcim_shift_acc: ACC_W must be >= PSUM_W + ACT_BITS");
  end

  sacc_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [ACC_W-1:0] psum_ext;
  logic [ACC_W-1:0] plane_val;

  assign psum_ext = {{(ACC_W-PSUM_W){bus.psum[PSUM_W-1]}}, bus.psum};

  // The first (MSB) plane carries negative weight for signed activations.
  always_comb begin
    plane_val = (acc_q << 1) + psum_ext;
    if (cnt_q == '0) begin
      plane_val = signed_q ? (ACC_W'(0) - psum_ext) : psum_ext;
    end
  end

`ifdef DCIM_SACC_RELU_EN
  logic clip_q, clip_d;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    out_data_d = out_data_q;
`ifdef DCIM_SACC_RELU_EN
    clip_d     = clip_q;
`endif
    case (state_q)
      SACC_IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          cnt_d    = '0;
          signed_d = bus.act_signed;
          state_d  = SACC_ACCUM;
        end
      end
      SACC_ACCUM: begin
        if (bus.in_valid) begin
          acc_d = plane_val;
          if (cnt_q == LAST_CNT) begin
            state_d    = SACC_DONE;
            out_data_d = plane_val;
`ifdef DCIM_SACC_RELU_EN
            clip_d = plane_val[ACC_W-1];
            if (plane_val[ACC_W-1]) begin
              out_data_d = '0;
            end
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SACC_DONE: begin
        if (bus.out_ready) begin
          state_d = SACC_IDLE;
        end
      end
      default: state_d = SACC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SACC_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      out_data_q <= '0;
`ifdef DCIM_SACC_RELU_EN
      clip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      out_data_q <= out_data_d;
`ifdef DCIM_SACC_RELU_EN
      clip_q     <= clip_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == SACC_ACCUM);
  assign bus.out_valid = (state_q == SACC_DONE);
  assign bus.busy      = (state_q != SACC_IDLE);
  assign bus.out_data  = out_data_q;
  assign state_dbg_o   = state_q;

`ifdef DCIM_SACC_RELU_EN
  assign bus.relu_clip = clip_q;
`else
  assign bus.relu_clip = 1'b0;
`endif

endmodule

// File: tb/tb_dcim_shift_acc.sv
// Randomized bench for dcim_shift_acc against an arithmetic dot-product model;
// honours DCIM_SACC_RELU_EN when defined.
module tb_dcim_shift_acc;
  import dcim_pkg::*;

  localparam int PSUM_W   = DCIM_PSUM_W;
  localparam int ACT_BITS = DCIM_ACT_BITS;
  localparam int ACC_W    = DCIM_ACC_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  sacc_state_e state_dbg;

  dcim_shift_acc_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();

  dcim_shift_acc #(.PSUM_W(PSUM_W), .ACT_BITS(ACT_BITS), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  int               psum_a[ACT_BITS];
  logic [ACC_W-1:0] exp_q[$];
  bit               clip_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Dot product straight from the plane weights 2^(ACT_BITS-1-k).
  function automatic logic [ACC_W-1:0] model(input bit sgn, output bit clip);
    longint s = 0;
    for (int k = 0; k < ACT_BITS; k++) begin
      longint term = longint'(psum_a[k]) * (longint'(1) << (ACT_BITS - 1 - k));
      if (k == 0 && sgn) s -= term;
      else               s += term;
    end
    clip = 1'b0;
`ifdef DCIM_SACC_RELU_EN
    if (s < 0) begin
      s    = 0;
      clip = 1'b1;
    end
`endif
    return ACC_W'(s);
  endfunction

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.act_signed = 1'b0;
    bus.in_valid   = 1'b0;
    bus.psum       = '0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(bus.out_data),  64'd0);
    chk({tag, "_busy"},      64'(bus.busy),      64'd0);
    chk({tag, "_relu_clip"}, 64'(bus.relu_clip), 64'd0);
  endtask

  // Issues start at the next edge, then feeds beats. mode 0: back-to-back,
  // 1: every other cycle, 2: random gaps. Returns after the edge that accepted
  // beat n_beats (n_beats < ACT_BITS leaves the operation in flight).
  task automatic start_and_feed(input bit sgn, input int mode, input int n_beats);
    int idx = 0;
    int t   = 0;
    bit v;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.act_signed = sgn;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.act_signed = 1'($urandom_range(0, 1));
    while (idx < n_beats && t < 200) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.psum     = v ? PSUM_W'(psum_a[idx]) : PSUM_W'($urandom);
      @(negedge clk);
      chk("accum_in_ready", 64'(bus.in_ready), 64'd1);
      chk("accum_no_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      if (v) idx++;
      t++;
      #1;
    end
    bus.in_valid = 1'b0;
    chk("beat_count", 64'(idx), 64'(n_beats));
    if (mode == 0) chk("first_beat_to_valid", 64'(t), 64'(n_beats));
  endtask

  task automatic run_op(input bit sgn, input int mode, input int hold);
    bit               clip_e;
    logic [ACC_W-1:0] exp_v;
    bit               exp_c;
    exp_q.push_back(model(sgn, clip_e));
    clip_q.push_back(clip_e);
    start_and_feed(sgn, mode, ACT_BITS);
    exp_v = exp_q.pop_front();
    exp_c = clip_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.start     = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("done_out_valid", 64'(bus.out_valid), 64'd1);
      chk("done_in_ready",  64'(bus.in_ready),  64'd0);
      chk("done_stable",    64'(bus.out_data),  64'(exp_v));
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    chk("result",         64'(bus.out_data),  64'(exp_v));
    chk("relu_clip",      64'(bus.relu_clip), 64'(exp_c));
    chk("result_valid",   64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    chk("post_hs_busy",      64'(bus.busy),      64'd0);
    chk("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hs_start_ignored",  64'(bus.busy),      64'd0);
    @(posedge clk); #1;
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < ACT_BITS; k++) psum_a[k] = v;
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // all-ones unsigned -> 255
    fill(1);
    run_op(1'b0, 0, 0);
    // MSB plane only: signed -128, unsigned +128
    fill(0); psum_a[0] = 1;
    run_op(1'b1, 0, 0);
    run_op(1'b0, 0, 0);
    // psum -3 on every plane, signed -> 3
    fill(-3);
    run_op(1'b1, 0, 0);
    // gapped feed with the all-ones pattern
    fill(1);
    run_op(1'b0, 1, 0);
    // back-pressure in DONE with start pulses
    fill(7); psum_a[3] = -100;
    run_op(1'b1, 0, 5);

    // reset in flight after 4 planes
    fill(2);
    start_and_feed(1'b0, 0, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_op_reset");
    @(posedge clk); #1;
    run_op(1'b0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < ACT_BITS; k++) psum_a[k] = int'($urandom_range(0, 65535)) - 32768;
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
